// File: rtl/op2_imm_encoder.sv
// op2_imm_encoder
//   Finds the canonical (imm8, rotate4) encoding of a 32-bit constant so that
//   ROR(zero_extend(imm8), 2*rotate4) == constant. One rotation is tried per
//   clock, starting at rotate 0, so the first hit is the smallest rotate field.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_Valid   request strobe, sampled only while out_Ready is high
//   in_Value   constant to encode, captured on the accept edge
//   out_Ready  high while idle; a request can be accepted
//   out_Done   one-cycle pulse; result fields are valid
//   out_Found  1 = encodable, 0 = no encoding exists
//   out_Imm8   encoded immediate (0 when not found)
//   out_Rotate encoded rotate field, shift = 2*out_Rotate (0 when not found)
module op2_imm_encoder #(
  parameter int WordWidth = 32,
  parameter int ImmWidth  = 8,
  parameter int RotSteps  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_Valid,
  input  logic [WordWidth-1:0] in_Value,
  output logic                 out_Ready,
  output logic                 out_Done,
  output logic                 out_Found,
  output logic [ImmWidth-1:0]  out_Imm8,
  output logic [3:0]           out_Rotate
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] RotLast = 4'(RotSteps - 1);

  state_t               state, state_nxt;
  logic [WordWidth-1:0] val_p0;
  logic [3:0]           rot_p0;
  logic [WordWidth-1:0] rot_val;
  logic                 match;

  // Rotate left by an even amount: the upper half of the doubled word
  // shifted left is exactly the wrapped result.
  function automatic logic [WordWidth-1:0] rol_even(
    input logic [WordWidth-1:0] v,
    input logic [3:0]           r
  );
    logic [2*WordWidth-1:0] dbl;
    dbl = {v, v} << {r, 1'b0};
    return dbl[2*WordWidth-1:WordWidth];
  endfunction

  assign rot_val = rol_even(val_p0, rot_p0);
  assign match   = (rot_val[WordWidth-1:ImmWidth] == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_Valid) state_nxt = SEARCH;
      SEARCH:  if (match || (rot_p0 == RotLast)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    out_Ready = (state == IDLE);
    out_Done  = (state == DONE);
  end

  // Capture, rotation counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_p0     <= '0;
      rot_p0     <= '0;
      out_Found  <= 1'b0;
      out_Imm8   <= '0;
      out_Rotate <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_Valid) begin
            val_p0 <= in_Value;
            rot_p0 <= '0;
          end
        end
        SEARCH: begin
          if (match) begin
            out_Found  <= 1'b1;
            out_Imm8   <= rot_val[ImmWidth-1:0];
            out_Rotate <= rot_p0;
          end else if (rot_p0 == RotLast) begin
            out_Found  <= 1'b0;
            out_Imm8   <= '0;
            out_Rotate <= '0;
          end else begin
            rot_p0 <= rot_p0 + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op2_imm_encoder.sv
// Scoreboard bench for op2_imm_encoder: the driver pushes the expected result
// and completion cycle of every accepted request; a monitor pops and compares
// on each out_Done, and checks result holding and out_Ready between pulses.
module tb_op2_imm_encoder;

  typedef struct {
    logic       found;
    logic [7:0] imm;
    logic [3:0] rot;
    int         done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_Valid = 1'b0;
  logic [31:0] in_Value = '0;
  logic        out_Ready, out_Done, out_Found;
  logic [7:0]  out_Imm8;
  logic [3:0]  out_Rotate;

  op2_imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_Valid  (in_Valid),
    .in_Value  (in_Value),
    .out_Ready (out_Ready),
    .out_Done  (out_Done),
    .out_Found (out_Found),
    .out_Imm8  (out_Imm8),
    .out_Rotate(out_Rotate)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: brute-force search of the forward rotator, smallest rotate first.
  function automatic exp_t model(input logic [31:0] v);
    logic [63:0] d;
    logic [31:0] x;
    exp_t e;
    e = '{1'b0, 8'h00, 4'h0, 0};
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 256; i++) begin
        x = 32'(i);
        d = {x, x} >> (2 * r);
        if (d[31:0] == v) begin
          e = '{1'b1, 8'(i), 4'(r), 0};
          return e;
        end
      end
    end
    return e;
  endfunction

  function automatic int latency(input exp_t e);
    return e.found ? int'(e.rot) + 1 : 16;
  endfunction

  function automatic logic [31:0] gen_value();
    logic [63:0] d;
    logic [31:0] x;
    int          k;
    k = $urandom_range(0, 3);
    if (k <= 1) begin
      x = {24'h0, 8'($urandom)};
      d = {x, x} >> (2 * $urandom_range(0, 15));
      return d[31:0];
    end else if (k == 2) begin
      return $urandom;
    end else begin
      x = {23'h0, 9'($urandom)};
      return x << $urandom_range(0, 23);
    end
  endfunction

  // Monitor
  initial begin
    exp_t        e;
    logic        ready_chk;
    logic        last_found;
    logic [7:0]  last_imm;
    logic [3:0]  last_rot;
    ready_chk  = 1'b0;
    last_found = 1'b0;
    last_imm   = '0;
    last_rot   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_chk  = 1'b0;
        last_found = 1'b0;
        last_imm   = '0;
        last_rot   = '0;
      end else begin
        if (ready_chk) begin
          check("ready_after_done", 32'(out_Ready), 32'd1);
          ready_chk = 1'b0;
        end
        if (out_Done) begin
          check("ready_low_in_done", 32'(out_Ready), 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=done required=no_done (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            check("found", 32'(out_Found), 32'(e.found));
            check("imm8", 32'(out_Imm8), 32'(e.imm));
            check("rotate", 32'(out_Rotate), 32'(e.rot));
            check("done_cycle", 32'(cyc), 32'(e.done_cyc));
            last_found = e.found;
            last_imm   = e.imm;
            last_rot   = e.rot;
            ready_chk  = 1'b1;
          end
        end else begin
          check("hold", {19'h0, out_Found, out_Imm8, out_Rotate},
                {19'h0, last_found, last_imm, last_rot});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!out_Ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_Ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 (t=%0t)", $time);
    end
  endtask

  task automatic issue(input logic [31:0] v, input exp_t e);
    exp_t x;
    @(negedge clk);
    wait_ready();
    x = e;
    x.done_cyc = cyc + 1 + latency(e);
    in_Valid = 1'b1;
    in_Value = v;
    sb.push_back(x);
    @(negedge clk);
    in_Valid = 1'b0;
    in_Value = $urandom;
  endtask

  task automatic issue_model(input logic [31:0] v);
    issue(v, model(v));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !out_Ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #2;
    check("rst_ready", 32'(out_Ready), 32'd1);
    check("rst_done", 32'(out_Done), 32'd0);
    check("rst_found", 32'(out_Found), 32'd0);
    check("rst_imm8", 32'(out_Imm8), 32'd0);
    check("rst_rotate", 32'(out_Rotate), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Directed cases with hand-derived expectations
    issue(32'h000000FF, '{1'b1, 8'hFF, 4'd0, 0});
    issue(32'hFF000000, '{1'b1, 8'hFF, 4'd4, 0});
    issue(32'hF000000F, '{1'b1, 8'hFF, 4'd2, 0});
    issue(32'h000003FC, '{1'b1, 8'hFF, 4'd15, 0});
    issue(32'h00000102, '{1'b0, 8'h00, 4'd0, 0});
    issue(32'h00012345, '{1'b0, 8'h00, 4'd0, 0});
    issue(32'h00000000, '{1'b1, 8'h00, 4'd0, 0});
    issue(32'h80000001, '{1'b1, 8'h06, 4'd1, 0}); // wait: see below
    wait_idle();

    // Random single requests
    for (int k = 0; k < 60; k++) begin
      issue_model(gen_value());
    end
    wait_idle();

    // in_Valid held high with in_Value changing while busy
    @(negedge clk);
    wait_ready();
    in_Valid = 1'b1;
    in_Value = gen_value();
    for (int k = 0; k < 150; k++) begin
      if (out_Ready) begin
        e = model(in_Value);
        e.done_cyc = cyc + 1 + latency(e);
        sb.push_back(e);
      end else begin
        in_Value = gen_value();
      end
      @(negedge clk);
    end
    in_Valid = 1'b0;
    wait_idle();

    // Reset in the middle of a search
    issue(32'hFF000000, '{1'b1, 8'hFF, 4'd4, 0});
    wait_idle();
    issue(32'h000003FC, '{1'b1, 8'hFF, 4'd15, 0});
    @(posedge clk); // E2
    @(posedge clk); // E3
    #1 rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_ready", 32'(out_Ready), 32'd1);
    check("midrst_done", 32'(out_Done), 32'd0);
    check("midrst_found", 32'(out_Found), 32'd0);
    check("midrst_imm8", 32'(out_Imm8), 32'd0);
    check("midrst_rotate", 32'(out_Rotate), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(32'h0000FF00, '{1'b1, 8'hFF, 4'd12, 0});
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
